// File: rtl/fb_bank_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_bank_scheduler_if
//  Description : Signal bundle between the camera write side, the display
//                read side and the triple-buffer frame bank scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fb_bank_scheduler_if #(
   parameter int AW = 17,
   parameter int DW = 32
);
   logic          frame_start;
   logic          frame_end;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          disp_vsync;
   logic [AW-1:0] rd_word_addr;
   logic          ram_we;
   logic [AW+1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [AW+1:0] ram_raddr;
   logic [1:0]    disp_bank;
   logic          frame_ready;
   logic [7:0]    frames_done;
   logic [7:0]    frames_dropped;
   logic          overflow;

   modport master (
      output frame_start, frame_end, wr_valid, wr_data, disp_vsync, rd_word_addr,
      input  ram_we, ram_waddr, ram_wdata, ram_raddr, disp_bank, frame_ready,
             frames_done, frames_dropped, overflow
   );

   modport slave (
      input  frame_start, frame_end, wr_valid, wr_data, disp_vsync, rd_word_addr,
      output ram_we, ram_waddr, ram_wdata, ram_raddr, disp_bank, frame_ready,
             frames_done, frames_dropped, overflow
   );
endinterface
`default_nettype wire

// File: rtl/fb_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fb_bank_scheduler
//  Description : Triple-buffer frame scheduler. Steers each camera frame into
//                the free bank, publishes complete frames and swaps the
//                displayed bank only on display vsync (no tearing).
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_bank_scheduler #(
   parameter int WORDS = 76800,
   parameter int AW    = 17,
   parameter int DW    = 32
) (
   input wire                 clk,
   input wire                 reset,
   fb_bank_scheduler_if.slave bus
);
   // word counter needs one extra bit so it can hold the value WORDS itself
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] c_words = CW'(WORDS);

   typedef enum logic [0:0] {
      W_IDLE   = 1'b0,
      W_ACTIVE = 1'b1
   } wstate_t;

   wstate_t       r_state, w_state_nxt;
   logic [1:0]    r_wbank, w_wbank_nxt;
   logic [CW-1:0] r_wcnt, w_wcnt_nxt;
   logic          r_bad, w_bad_nxt;
   logic          r_ram_we, w_we_nxt;
   logic [AW+1:0] r_ram_waddr, w_waddr_nxt;
   logic [DW-1:0] r_ram_wdata, w_wdata_nxt;
   logic [AW+1:0] r_ram_raddr;
   logic [1:0]    r_disp_bank, w_disp_nxt;
   logic [1:0]    r_latest_bank, w_latest_nxt;
   logic          r_latest_valid, w_valid_nxt;
   logic          r_frame_ready, w_ready_nxt;
   logic [7:0]    r_frames_done;
   logic [7:0]    r_frames_dropped;
   logic          r_overflow;
   logic          w_done_inc, w_drop_inc, w_over_set;

   logic          w_vs_take;
   logic [1:0]    w_vs_disp;
   logic [1:0]    w_vs_latest;
   logic [1:0]    w_free_bank;
   logic          w_restart;

   // Vsync swaps displayed and latest banks when a fresh frame is waiting.
   // Everything downstream (free bank, commit) sees the post-vsync view.
   assign w_vs_take   = bus.disp_vsync & r_latest_valid;
   assign w_vs_disp   = w_vs_take ? r_latest_bank : r_disp_bank;
   assign w_vs_latest = w_vs_take ? r_disp_bank   : r_latest_bank;
   // codes 0+1+2 = 3, so the remaining code is 3 minus the two in use
   assign w_free_bank = 2'd3 - w_vs_disp - w_vs_latest;
   // a new frame_start without frame_end abandons the current frame
   assign w_restart   = bus.frame_start & ~bus.frame_end;

   // Next-state, write-path and bank bookkeeping decisions
   always_comb begin
      w_state_nxt  = r_state;
      w_wbank_nxt  = r_wbank;
      w_wcnt_nxt   = r_wcnt;
      w_bad_nxt    = r_bad;
      w_we_nxt     = 1'b0;
      w_waddr_nxt  = r_ram_waddr;
      w_wdata_nxt  = r_ram_wdata;
      w_disp_nxt   = w_vs_disp;
      w_latest_nxt = w_vs_latest;
      w_valid_nxt  = r_latest_valid & ~bus.disp_vsync;
      w_ready_nxt  = r_frame_ready;
      w_done_inc   = 1'b0;
      w_drop_inc   = 1'b0;
      w_over_set   = 1'b0;

      case (r_state)
         W_IDLE: begin
            if (bus.frame_start) begin
               w_state_nxt = W_ACTIVE;
               w_wbank_nxt = w_free_bank;
               w_wcnt_nxt  = '0;
               w_bad_nxt   = 1'b0;
            end
         end
         W_ACTIVE: begin
            // the word arriving with frame_end still belongs to this frame
            if (bus.wr_valid && !w_restart) begin
               if (r_wcnt < c_words) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = {r_wbank, r_wcnt[AW-1:0]};
                  w_wdata_nxt = bus.wr_data;
                  w_wcnt_nxt  = r_wcnt + CW'(1);
               end else begin
                  w_over_set = 1'b1;
                  w_bad_nxt  = 1'b1;
               end
            end
            if (bus.frame_end) begin
               w_state_nxt = W_IDLE;
               if ((w_wcnt_nxt == c_words) && !w_bad_nxt) begin
                  // commit overrides any same-cycle vsync update of latest
                  w_latest_nxt = r_wbank;
                  w_valid_nxt  = 1'b1;
                  w_ready_nxt  = 1'b1;
                  w_done_inc   = 1'b1;
               end else begin
                  w_drop_inc = 1'b1;
               end
            end else if (bus.frame_start) begin
               // restart in the same bank; it is still free
               w_drop_inc = 1'b1;
               w_wcnt_nxt = '0;
               w_bad_nxt  = 1'b0;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= W_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Write-side datapath: target bank, word count and RAM port A
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wbank     <= 2'd0;
         r_wcnt      <= '0;
         r_bad       <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_waddr <= '0;
         r_ram_wdata <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_wbank     <= w_wbank_nxt;
         r_wcnt      <= w_wcnt_nxt;
         r_bad       <= w_bad_nxt;
         r_ram_we    <= w_we_nxt;
         r_ram_waddr <= w_waddr_nxt;
         r_ram_wdata <= w_wdata_nxt;
         r_overflow  <= r_overflow | w_over_set;
      end
   end

   // Bank ownership and registered display read address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_disp_bank    <= 2'd0;
         r_latest_bank  <= 2'd1;
         r_latest_valid <= 1'b0;
         r_frame_ready  <= 1'b0;
         r_ram_raddr    <= '0;
      end else begin
         r_disp_bank    <= w_disp_nxt;
         r_latest_bank  <= w_latest_nxt;
         r_latest_valid <= w_valid_nxt;
         r_frame_ready  <= w_ready_nxt;
         r_ram_raddr    <= {r_disp_bank, bus.rd_word_addr};
      end
   end

   // Saturating frame statistics
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frames_done    <= 8'd0;
         r_frames_dropped <= 8'd0;
      end else begin
         if (w_done_inc && (r_frames_done != 8'hFF))
            r_frames_done <= r_frames_done + 8'd1;
         if (w_drop_inc && (r_frames_dropped != 8'hFF))
            r_frames_dropped <= r_frames_dropped + 8'd1;
      end
   end

   assign bus.ram_we         = r_ram_we;
   assign bus.ram_waddr      = r_ram_waddr;
   assign bus.ram_wdata      = r_ram_wdata;
   assign bus.ram_raddr      = r_ram_raddr;
   assign bus.disp_bank      = r_disp_bank;
   assign bus.frame_ready    = r_frame_ready;
   assign bus.frames_done    = r_frames_done;
   assign bus.frames_dropped = r_frames_dropped;
   assign bus.overflow       = r_overflow;

endmodule
`default_nettype wire
